mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 25 ++
 rtl/mul_div_unit_if.sv | 29 ++
 rtl/mul_div_unit_div_iter.sv | 24 ++
 rtl/mul_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// controller states and the default operand width.
package muldiv_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_MADD  = 3'd2,
      OP_MSUB  = 3'd3,
      OP_DIV   = 3'd4,
      OP_DIVU  = 3'd5,
      OP_MTHI  = 3'd6,
      OP_MTLO  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO unit.
// master = pipeline side, slave = mul_div_unit.
interface mul_div_unit_if
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic             Start;
   op_e              Op;
   logic [WIDTH-1:0] OperandA;
   logic [WIDTH-1:0] OperandB;
   logic             HiLoRead;
   logic             Busy;
   logic             Done;
   logic             DivByZero;
   logic             Stall;
   logic [WIDTH-1:0] HiData;
   logic [WIDTH-1:0] LoData;

   modport master (
      output Start, Op, OperandA, OperandB, HiLoRead,
      input  Busy, Done, DivByZero, Stall, HiData, LoData
   );

   modport slave (
      input  Start, Op, OperandA, OperandB, HiLoRead,
      output Busy, Done, DivByZero, Stall, HiData, LoData
   );
endinterface

// File: rtl/mul_div_unit_div_iter.sv
// One step of unsigned restoring division: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, and keep the
// difference only when it did not go negative.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] dvd_i,
   input  logic [WIDTH-1:0] dvsr_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           q_bit;

   // The partial remainder is always below the divisor, so one extra bit
   // is enough for the trial difference's sign to be exact.
   assign shifted = {rem_i, dvd_i[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvsr_i};
   assign q_bit   = ~trial[WIDTH];
   assign rem_o   = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign quo_o   = {dvd_i[WIDTH-2:0], q_bit};
endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (MIPS style).
// Multiplies run shift-add on operand magnitudes for WIDTH cycles, then a
// FIX cycle applies sign and MADD/MSUB accumulation. Divides use the
// restoring div_iter step when MULDIV_DIV_EN is defined; without it DIV and
// DIVU complete immediately as a divide-by-zero.
module mul_div_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic         Clk,
   input logic         Rst,
   mul_div_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_e             state_q;
   op_e                op_q;
   logic [WIDTH-1:0]   a_q;        // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q;      // {upper, lower} shift register
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_q;      // negate product / quotient in FIX
   logic               rneg_q;     // negate remainder in FIX
   logic               busy_q;
   logic               done_q;
   logic               dbz_q;
   logic               dbz_pend_q; // divide-by-zero reported one edge later
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               signed_op;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_acc_d;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] fix_mul_d;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic               div_op_q;

   assign signed_op = (bus.Op == OP_MULT) || (bus.Op == OP_MADD) ||
                      (bus.Op == OP_MSUB) || (bus.Op == OP_DIV);
   assign a_mag = (signed_op && bus.OperandA[WIDTH-1]) ? -bus.OperandA : bus.OperandA;
   assign b_mag = (signed_op && bus.OperandB[WIDTH-1]) ? -bus.OperandB : bus.OperandB;

   // Shift-add step: conditionally add the multiplicand into the upper half,
   // then shift the whole register right, consuming one multiplier bit.
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
   assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

   assign prod_s   = neg_q ? -acc_q : acc_q;
   assign quo_s    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_s    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   assign div_op_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

   // Final multiply result: plain product, or accumulated into {HI,LO}.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      fix_mul_d = prod_s;
      case (op_q)
         OP_MADD: fix_mul_d = {hi_q, lo_q} + prod_s;
         OP_MSUB: fix_mul_d = {hi_q, lo_q} - prod_s;
         default: fix_mul_d = prod_s;
      endcase
   end

`ifdef MULDIV_DIV_EN
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   div_quo;
   logic [2*WIDTH-1:0] div_acc_d;

   div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .rem_i  (acc_q[2*WIDTH-1:WIDTH]),
      .dvd_i  (acc_q[WIDTH-1:0]),
      .dvsr_i (a_q),
      .rem_o  (div_rem),
      .quo_o  (div_quo)
   );
   assign div_acc_d = {div_rem, div_quo};
`endif

   // Controller, datapath registers and registered outputs.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_MULT;
         a_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         dbz_pend_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         dbz_pend_q <= 1'b0;
         if (dbz_pend_q) begin
            done_q <= 1'b1;
            dbz_q  <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.Start) begin
                  op_q  <= bus.Op;
                  cnt_q <= '0;
                  case (bus.Op)
                     OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                        a_q     <= a_mag;
                        acc_q   <= {{WIDTH{1'b0}}, b_mag};
                        neg_q   <= signed_op & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
                        rneg_q  <= 1'b0;
                     end
                     OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                        if (bus.OperandB == '0) begin
                           dbz_pend_q <= 1'b1;
                        end else begin
                           state_q <= ST_DIV;
                           busy_q  <= 1'b1;
                           a_q     <= b_mag;
                           acc_q   <= {{WIDTH{1'b0}}, a_mag};
                           neg_q   <= signed_op & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
                           rneg_q  <= signed_op & bus.OperandA[WIDTH-1];
                        end
`else
                        dbz_pend_q <= 1'b1;
`endif
                     end
                     OP_MTHI: begin
                        hi_q   <= bus.OperandA;
                        done_q <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo_q   <= bus.OperandA;
                        done_q <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               acc_q <= mul_acc_d;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_FIX;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DIV: begin
`ifdef MULDIV_DIV_EN
               acc_q <= div_acc_d;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_FIX;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`else
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
`endif
            end
            ST_FIX: begin
               if (div_op_q) begin
                  hi_q <= rem_s;
                  lo_q <= quo_s;
               end else begin
                  {hi_q, lo_q} <= fix_mul_d;
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.DivByZero = dbz_q;
   assign bus.HiData    = hi_q;
   assign bus.LoData    = lo_q;
   assign bus.Stall     = bus.HiLoRead & (busy_q | bus.Start);
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit at WIDTH=32. A cycle-level model
// computes results with plain 64-bit arithmetic; a compare process checks
// every output each cycle, and directed operations pin hand-computed values.
// Honours MULDIV_DIV_EN the same way the design does.
module tb_mul_div_unit;
   import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int W  = 32;
   localparam int LAT = W + 1;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   cmp_en   = 1'b0;

   mul_div_unit_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        m_busy = 0, m_done = 0, m_dbz = 0, m_dbz_pend = 0;
   logic [31:0] m_hi = 0, m_lo = 0, r_hi = 0, r_lo = 0;
   int          m_left = 0;

   initial begin
      logic [63:0] res;
      longint sa, sb, p;
      forever begin
         @(posedge Clk or posedge Rst);
         if (Rst) begin
            m_busy = 0; m_done = 0; m_dbz = 0; m_dbz_pend = 0;
            m_hi = 0; m_lo = 0; m_left = 0;
         end else begin
            m_done = 0;
            m_dbz  = 0;
            if (m_dbz_pend) begin
               m_done = 1; m_dbz = 1; m_dbz_pend = 0;
            end
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_busy = 0; m_done = 1; m_hi = r_hi; m_lo = r_lo;
               end
            end else if (bus.Start) begin
               sa  = $signed(bus.OperandA);
               sb  = $signed(bus.OperandB);
               p   = sa * sb;
               res = 64'd0;
               case (bus.Op)
                  OP_MULT:  res = p;
                  OP_MULTU: res = {32'd0, bus.OperandA} * {32'd0, bus.OperandB};
                  OP_MADD:  res = {m_hi, m_lo} + p;
                  OP_MSUB:  res = {m_hi, m_lo} - p;
                  OP_DIV:   if (DIV_EN && bus.OperandB != 0) begin
                     longint q, r;
                     q = sa / sb;
                     r = sa % sb;
                     res = {r[31:0], q[31:0]};
                  end
                  OP_DIVU:  if (DIV_EN && bus.OperandB != 0)
                     res = {bus.OperandA % bus.OperandB, bus.OperandA / bus.OperandB};
                  default:  res = 64'd0;
               endcase
               if (bus.Op == OP_MTHI) begin
                  m_hi = bus.OperandA; m_done = 1;
               end else if (bus.Op == OP_MTLO) begin
                  m_lo = bus.OperandA; m_done = 1;
               end else if ((bus.Op == OP_DIV || bus.Op == OP_DIVU) &&
                            (!DIV_EN || bus.OperandB == 0)) begin
                  m_dbz_pend = 1;
               end else begin
                  m_left = LAT; m_busy = 1;
                  r_hi = res[63:32]; r_lo = res[31:0];
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      wait (cmp_en);
      forever begin
         @(negedge Clk);
         #2;
         check("cyc_busy",  bus.Busy,      m_busy);
         check("cyc_done",  bus.Done,      m_done);
         check("cyc_dbz",   bus.DivByZero, m_dbz);
         check("cyc_stall", bus.Stall,     bus.HiLoRead & (m_busy | bus.Start));
         check("cyc_hi",    bus.HiData,    m_hi);
         check("cyc_lo",    bus.LoData,    m_lo);
      end
   end

   // Issue one operation, scramble inputs after acceptance, wait for Done.
   task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input int second_at, output int lat, output logic dbz,
                         output logic busy_seen);
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
      @(posedge Clk);
      #1;
      lat = -1; dbz = 1'b0; busy_seen = bus.Busy;
      if (bus.Done) begin
         lat = 0; dbz = bus.DivByZero;
      end
      for (int k = 1; k <= 45 && lat < 0; k++) begin
         @(negedge Clk);
         bus.Start    = (k == second_at);
         bus.Op       = (k == second_at) ? OP_MTHI : OP_MTLO;
         bus.OperandA = (k == second_at) ? 32'h1234_5678 : $urandom;
         bus.OperandB = $urandom;
         @(posedge Clk);
         #1;
         busy_seen |= bus.Busy;
         if (bus.Done) begin
            lat = k; dbz = bus.DivByZero;
         end
      end
      @(negedge Clk);
      bus.Start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, done_cnt;
      logic dbz, bsy;
      bus.Start = 0; bus.Op = OP_MULT; bus.OperandA = 0; bus.OperandB = 0; bus.HiLoRead = 0;
      #1 Rst = 1'b1;
      #1;
      check("rst_busy", bus.Busy, 0);
      check("rst_done", bus.Done, 0);
      check("rst_dbz",  bus.DivByZero, 0);
      check("rst_hi",   bus.HiData, 0);
      check("rst_lo",   bus.LoData, 0);
      cmp_en = 1'b1;
      repeat (2) @(negedge Clk);
      Rst = 1'b0;

      run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, 0, lat, dbz, bsy);
      check("mult_lat", lat, 33);
      check("mult_hi", bus.HiData, 32'hFFFF_FFFF);
      check("mult_lo", bus.LoData, 32'hFFFF_FFFE);

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 0, lat, dbz, bsy);
      check("multu_hi", bus.HiData, 32'h0000_0001);
      check("multu_lo", bus.LoData, 32'hFFFF_FFFE);

      run_op(OP_MTHI, 32'h0, 32'h0, 0, lat, dbz, bsy);
      check("mthi_lat", lat, 0);
      check("mthi_busy", bsy, 0);
      run_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, 0, lat, dbz, bsy);
      check("mtlo_hi_kept", bus.HiData, 32'h0);
      check("mtlo_lo", bus.LoData, 32'hFFFF_FFFF);
      run_op(OP_MADD, 32'h1, 32'h1, 0, lat, dbz, bsy);
      check("madd_hi", bus.HiData, 32'h1);
      check("madd_lo", bus.LoData, 32'h0);

      run_op(OP_MSUB, 32'h3, 32'hFFFF_FFFE, 0, lat, dbz, bsy);
      check("msub_hi", bus.HiData, 32'h1);
      check("msub_lo", bus.LoData, 32'h6);

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 0, lat, dbz, bsy);
      if (DIV_EN) begin
         check("div_lat", lat, 33);
         check("div_dbz", dbz, 0);
         check("div_lo", bus.LoData, 32'hFFFF_FFFD);
         check("div_hi", bus.HiData, 32'hFFFF_FFFF);
      end else begin
         check("div_off_lat", lat, 1);
         check("div_off_dbz", dbz, 1);
         check("div_off_hi", bus.HiData, 32'h1);
         check("div_off_lo", bus.LoData, 32'h6);
      end

      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, dbz, bsy);
      if (DIV_EN) begin
         check("divmin_dbz", dbz, 0);
         check("divmin_lo", bus.LoData, 32'h8000_0000);
         check("divmin_hi", bus.HiData, 32'h0);
      end

      run_op(OP_DIV, 32'h7, 32'hFFFF_FFFD, 0, lat, dbz, bsy);
      if (DIV_EN) begin
         check("div7_lo", bus.LoData, 32'hFFFF_FFFE);
         check("div7_hi", bus.HiData, 32'h1);
      end

      begin
         logic [31:0] hi0, lo0;
         hi0 = m_hi; lo0 = m_lo;
         run_op(OP_DIVU, 32'h5, 32'h0, 0, lat, dbz, bsy);
         check("dbz_lat", lat, 1);
         check("dbz_flag", dbz, 1);
         check("dbz_busy", bsy, 0);
         check("dbz_hi_kept", bus.HiData, hi0);
         check("dbz_lo_kept", bus.LoData, lo0);
      end

      // Second Start ignored while busy; HiLoRead held high the whole time.
      bus.HiLoRead = 1'b1;
      run_op(OP_MULT, 32'h7, 32'hFFFF_FFFD, 5, lat, dbz, bsy);
      check("ign_lat", lat, 33);
      check("ign_hi", bus.HiData, 32'hFFFF_FFFF);
      check("ign_lo", bus.LoData, 32'hFFFF_FFEB);
      check("ign_stall_after", bus.Stall, 0);

      // Reset in the middle of a multiply.
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_MULT; bus.OperandA = 32'h3; bus.OperandB = 32'h5;
      @(posedge Clk);
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (9) @(posedge Clk);
      #1;
      check("mid_busy", bus.Busy, 1);
      check("mid_stall", bus.Stall, 1);
      #2 Rst = 1'b1;
      #1;
      check("midrst_busy", bus.Busy, 0);
      check("midrst_hi", bus.HiData, 0);
      check("midrst_lo", bus.LoData, 0);
      @(negedge Clk);
      Rst = 1'b0;
      bus.HiLoRead = 1'b0;
      done_cnt = 0;
      repeat (40) begin
         @(posedge Clk);
         #1;
         if (bus.Done) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 0);

      @(negedge Clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
